// File: rtl/hazard_scoreboard.sv
// Load-use / branch hazard scoreboard with E>M>W operand forwarding selects.
// Define HZ_FWD_EN to enable forwarding; otherwise RAW hazards on E/M/W stall decode.
module hazard_scoreboard #(
  parameter int REG_AW   = 3,
  parameter int LOAD_LAT = 1,
  parameter int BR_LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_D,
  input  logic [REG_AW-1:0] srcA_D,
  input  logic [REG_AW-1:0] srcB_D,
  input  logic [REG_AW-1:0] dst_D,
  input  logic              regwrite_D,
  input  logic              load_D,
  input  logic              branch_D,
  input  logic [REG_AW-1:0] dst_E,
  input  logic              regwrite_E,
  input  logic [REG_AW-1:0] dst_M,
  input  logic              regwrite_M,
  input  logic [REG_AW-1:0] dst_W,
  input  logic              regwrite_W,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              stall_F,
  output logic              stall_D,
  output logic              flush_D,
  output logic              bubble_E
);

  localparam int unsigned NREG = 1 << REG_AW;

  typedef enum logic {IDLE, BR_WAIT} state_t;

  state_t     state;
  logic [3:0] bcnt;
  logic [2:0] cnt [NREG];
  logic       pend_a, pend_b, haz, ld_stall, issue, in_bw;

  assign pend_a   = (srcA_D != '0) && (cnt[srcA_D] != '0);
  assign pend_b   = (srcB_D != '0) && (cnt[srcB_D] != '0);
  assign ld_stall = valid_D && (pend_a || pend_b || haz);
  assign in_bw    = (state == BR_WAIT);
  assign issue    = valid_D && !ld_stall && (state == IDLE);

`ifdef HZ_FWD_EN
  function automatic logic [1:0] fwd(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (regwrite_E && dst_E == src)      sel = 2'b01;
      else if (regwrite_M && dst_M == src) sel = 2'b10;
      else if (regwrite_W && dst_W == src) sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    ForwardA = fwd(srcA_D);
    ForwardB = fwd(srcB_D);
    haz      = 1'b0;
  end
`else
  // Without a bypass network any in-flight producer of a source is a hazard.
  function automatic logic raw(input logic [REG_AW-1:0] src);
    return (src != '0) &&
           ((regwrite_E && dst_E == src) ||
            (regwrite_M && dst_M == src) ||
            (regwrite_W && dst_W == src));
  endfunction

  always_comb begin
    ForwardA = '0;
    ForwardB = '0;
    haz      = raw(srcA_D) || raw(srcB_D);
  end
`endif

  // Load stall masks the branch flush: the held decode instruction must survive.
  always_comb begin
    stall_F  = ld_stall || (issue && branch_D) || in_bw;
    stall_D  = ld_stall;
    bubble_E = ld_stall;
    flush_D  = in_bw && !ld_stall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
      state <= IDLE;
      bcnt  <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (issue && load_D && regwrite_D && dst_D == REG_AW'(r))
          cnt[r] <= 3'(LOAD_LAT);
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 3'd1;
      end
      case (state)
        IDLE: begin
          if (issue && branch_D) begin
            state <= BR_WAIT;
            bcnt  <= 4'(BR_LAT);
          end
        end
        BR_WAIT: begin
          bcnt <= bcnt - 4'd1;
          if (bcnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-high, port reset.
REQ-002 The block SHALL have parameter REG_AW, default 3, register address width.
REQ-003 The block SHALL have parameter LOAD_LAT, default 1, load-use stall cycles, legal range 1..7.
REQ-004 The block SHALL have parameter BR_LAT, default 2, branch-resolution wait cycles, legal range 1..15.
REQ-005 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk  in  1  clock
- reset  in  1  async active-high reset
- valid_D  in  1  decode holds a valid instruction
- srcA_D  in  REG_AW  source A; 0 = unused
- srcB_D  in  REG_AW  source B; 0 = unused
- dst_D  in  REG_AW  decode destination
- regwrite_D  in  1  decode writes dst_D
- load_D  in  1  decode instruction is a load
- branch_D  in  1  decode instruction is a branch
- dst_E  in  REG_AW  execute destination
- regwrite_E  in  1  execute write enable
- dst_M  in  REG_AW  memory destination
- regwrite_M  in  1  memory write enable
- dst_W  in  REG_AW  write-back destination
- regwrite_W  in  1  write-back write enable
- ForwardA  out  2  source A select: 00 regfile, 01 E, 10 M, 11 W
- ForwardB  out  2  source B select, same encoding
- stall_F  out  1  hold fetch PC/register
- stall_D  out  1  hold decode register
- flush_D  out  1  load bubble into decode register
- bubble_E  out  1  load bubble into execute register

Function
REQ-006 The block SHALL keep a LOAD_LAT-sized down-counter per register (cnt[r], r = 1..2^REG_AW-1); register 0 is never pending.
REQ-007 The block SHALL define issue = valid_D & ~ld_stall & (state == IDLE).
REQ-008 The block SHALL, on each clock edge, decrement every nonzero cnt by 1; on the same edge, issue & load_D & regwrite_D & (dst_D != 0) SHALL load cnt[dst_D] = LOAD_LAT; the load takes priority over the decrement.
REQ-009 The block SHALL define ld_stall = valid_D & ((srcA_D != 0 & cnt[srcA_D] != 0) | (srcB_D != 0 & cnt[srcB_D] != 0)), combinational.
REQ-010 While ld_stall is high, the block SHALL drive stall_F = stall_D = bubble_E = 1 and flush_D = 0.
REQ-011 The block SHALL implement a two-state FSM: IDLE, BR_WAIT; a 4-bit bcnt is loaded with BR_LAT on IDLE -> BR_WAIT.
- IDLE -> BR_WAIT on issue & branch_D.
- In BR_WAIT, bcnt decrements each edge; BR_WAIT -> IDLE on the edge where bcnt == 1.
REQ-012 The block SHALL assert stall_F combinationally in the issue cycle of a branch, and stall_F = flush_D = 1 in every BR_WAIT cycle, giving BR_LAT+1 fetch-stall cycles in total.
REQ-013 When ld_stall coincides with branch_D, ld_stall SHALL win and the branch SHALL NOT be accepted until ld_stall drops.
REQ-014 A load that is also a branch SHALL perform both actions.
REQ-015 Pending counters SHALL keep counting down during BR_WAIT.
REQ-016 Forwarding priority per source SHALL be E > M > W, applied only when src != 0 and the matching regwrite is set; otherwise the select SHALL be 00.
REQ-017 All forwarding outputs SHALL be combinational with zero latency; the stall outputs SHALL depend only on current inputs and registered state.

Reset
REQ-018 Asserting reset SHALL immediately clear all cnt to 0, set the FSM to IDLE and clear bcnt, at any time including mid-stall.
REQ-019 After reset, the block SHALL drive stall_F = stall_D = flush_D = bubble_E = 0; ForwardA/ForwardB SHALL follow the REQ-016 combinational logic.

Configuration
REQ-020 The block SHALL use macro HZ_FWD_EN.
- Defined: forwarding as in REQ-016.
- Undefined: ForwardA = ForwardB = 00 constant, and ld_stall additionally asserts when any nonzero source equals dst_E, dst_M or dst_W with the corresponding regwrite set.

Verification
REQ-021 Load r3 issued at cycle t, consumer with srcA_D = 3 at t+1, LOAD_LAT = 2 -> stall_F = stall_D = bubble_E = 1 at t+1 and t+2; consumer issues at t+3.
REQ-022 Branch issued at t, BR_LAT = 2 -> stall_F = 1 at t, t+1, t+2; flush_D = 1 at t+1 and t+2; state is IDLE at t+3.
REQ-023 srcA_D = 5 with dst_E = dst_M = 5, both regwrite set -> ForwardA = 01; with regwrite_E = 0 -> 10; with srcA_D = 0 -> 00.
REQ-024 Branch in decode while cnt[srcB_D] != 0 -> no BR_WAIT entry until the stall clears; BR_WAIT entered on the first non-stalled cycle.
REQ-025 Reset pulse in mid-BR_WAIT with cnt[2] = 1 -> all stall outputs 0 immediately; a consumer of r2 issues without stall.
REQ-026 With HZ_FWD_EN undefined, srcA_D = 4 and dst_M = 4, regwrite_M = 1 -> ForwardA = 00 and stall_F = 1.
